pn_lfsr_stream_gen: RTL and testbench
=====================================

Name: pn_lfsr_stream_gen

Overview:
Parametrised pseudo-noise generator with a Fibonacci LFSR of configurable width and tap polynomial.
- Accepts a seed and a beat count over a ready/valid load port.
- Emits OUT_W PN bits per beat on an AXI-Stream-style master port with full backpressure and TLAST.
- Successor to the fixed 3-bit PN generator; used wherever test or whitening sequences feed stream datapaths.

Parameters:
LFSR_W, 7, LFSR register width (>=2).
TAPS, 7'b1100000, feedback mask; feedback = XOR of lfsr bits where TAPS bit is 1.
OUT_W, 8, PN bits packed per output beat (>=1).
LEN_W, 16, width of the beat-count field.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
seed_valid  in  1  load request
seed_ready  out  1  generator can accept a load
seed_data  in  LFSR_W  LFSR seed
seed_len  in  LEN_W  number of beats to emit
abort  in  1  synchronous cancel of the current run
m_tvalid  out  1  output beat valid
m_tready  in  1  downstream accepts beat
m_tdata  out  OUT_W  packed PN bits, bit0 = earliest bit
m_tlast  out  1  final beat of the run
busy  out  1  high in RUN
seed_zero_err  out  1  one-cycle pulse, all-zero seed replaced

Behaviour:
- Reset values: state=IDLE, lfsr=1, count=0, seed_ready=0, m_tvalid=0, m_tdata=0, m_tlast=0, busy=0, seed_zero_err=0. All outputs are registered.
- LFSR step:
  - out_bit = lfsr[0]
  - fb = ^(lfsr & TAPS)
  - lfsr_next = {fb, lfsr[LFSR_W-1:1]}
- Beat generation: one beat = OUT_W consecutive steps, unrolled combinationally. Step k's out_bit goes to m_tdata[k].
- IDLE:
  - seed_ready=1; m_tvalid=0.
  - On seed_valid&&seed_ready, seed_data is taken as the LFSR state.
  - If seed_data==0, the LFSR state becomes 1 and seed_zero_err pulses for one cycle.
  - If seed_len==0: no output, stay IDLE; seed_ready stays 1.
  - Otherwise, on the next edge: m_tdata = first beat, m_tvalid=1, m_tlast=(seed_len==1), count=seed_len-1, lfsr advanced OUT_W steps, state=RUN, seed_ready=0.
  - Load latency: one cycle from the load handshake to the first valid beat.
- RUN:
  - seed_ready=0; busy=1.
  - m_tdata, m_tvalid and m_tlast hold stable while m_tvalid&&!m_tready (AXI rule).
  - Handshake with count>0: next beat loads on the same edge, count-=1, m_tlast=(count==1). Gives one beat per cycle with m_tready held high.
  - Handshake with m_tlast=1: m_tvalid=0, m_tlast=0, state=IDLE, seed_ready=1 on the next cycle. No bubble-free reload is possible; at least one idle cycle between runs.
- abort (in RUN, any priority over handshake):
  - Next edge: m_tvalid=0, m_tlast=0, state=IDLE.
  - The beat being offered is dropped even if m_tready was high that cycle.
  - abort in IDLE has no effect.
- Wrap-around:
  - The LFSR runs free across beats; no reseed between beats.
  - The period is 2^LFSR_W-1 for a primitive TAPS; the block does not check primitivity.
- Reset mid-run returns all state to reset values immediately (asynchronous); downstream sees m_tvalid drop without TLAST.
- Counter width is LEN_W; maximum run is 2^LEN_W-1 beats.

Decomposition:
- Package pn_gen_pkg:
  - state enum {IDLE, RUN}
  - default TAPS constants for common polynomials (PN7 x^7+x^6+1, PN9, PN15, PN23)
  - a function lfsr_step(lfsr, taps) returning {next_state, out_bit}
- Sub-module pn_lfsr_unroll: combinational, takes lfsr and produces OUT_W bits plus the advanced lfsr. Reusable by a future checker/receiver block.

Test Plan:
All cases use LFSR_W=3, TAPS=3'b011, OUT_W=7, LEN_W=4.
1. Load seed 3'b001, len 2, tready=1 → beats 7'h69, 7'h69 on consecutive cycles; tlast on the second; seed_ready back to 1 one cycle later.
2. Same load with tready=0 for 5 cycles after the first valid → m_tdata=7'h69 and m_tvalid held stable throughout; a single beat is transferred when tready rises.
3. Load seed 3'b000, len 1 → seed_zero_err pulses once; output beat 7'h69 with tlast=1.
4. Load len 0 → no m_tvalid ever; seed_ready remains 1; the next load is accepted immediately.
5. Len 15, assert abort after the 3rd handshake → m_tvalid=0 the next cycle, no tlast, busy=0; a new load yields 7'h69 for seed 001.
6. Assert reset low mid-run with tvalid=1 → all outputs at reset values asynchronously; after release, seed_ready=1 on the first clock.

Source files
------------

// File: rtl/pn_gen_pkg.sv
// Shared types, default polynomials and the single-step LFSR helper for the PN generator family.
package pn_gen_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Widest LFSR the step helper can handle; blocks pad their register up to this.
  localparam int LFSR_MAX_W = 64;

  localparam logic [6:0]  PN7_TAPS  = 7'b1100000;              // x^7+x^6+1
  localparam logic [8:0]  PN9_TAPS  = 9'b1_0001_0000;          // x^9+x^5+1
  localparam logic [14:0] PN15_TAPS = 15'h6000;                // x^15+x^14+1
  localparam logic [22:0] PN23_TAPS = 23'h42_0000;             // x^23+x^18+1

  // Returns {next_state, out_bit}; bits of lfsr at or above w must be zero.
  function automatic logic [LFSR_MAX_W:0] lfsr_step(input logic [LFSR_MAX_W-1:0] lfsr,
                                                    input logic [LFSR_MAX_W-1:0] taps,
                                                    input int unsigned           w);
    logic                  fb;
    logic [LFSR_MAX_W-1:0] nxt;
    fb  = ^(lfsr & taps);
    nxt = (lfsr >> 1) | ({{(LFSR_MAX_W-1){1'b0}}, fb} << (w - 1));
    return {nxt, lfsr[0]};
  endfunction

endpackage

// File: rtl/pn_lfsr_unroll.sv
// Combinational OUT_W-step Fibonacci LFSR unroll; bits_o[0] is the earliest output bit.
module pn_lfsr_unroll import pn_gen_pkg::*; #(
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] TAPS   = 7'b1100000,
  parameter int                OUT_W  = 8
) (
  input  logic [LFSR_W-1:0] lfsr_i,
  output logic [OUT_W-1:0]  bits_o,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [OUT_W:0][LFSR_W-1:0] chain;

  assign chain[0] = lfsr_i;

  for (genvar k = 0; k < OUT_W; k++) begin : g_step
    logic [LFSR_MAX_W:0] r;
    logic                unused_hi;
    assign r           = lfsr_step(LFSR_MAX_W'(chain[k]), LFSR_MAX_W'(TAPS), LFSR_W);
    assign chain[k+1]  = r[LFSR_W:1];
    assign bits_o[k]   = r[0];
    assign unused_hi   = ^r[LFSR_MAX_W:LFSR_W+1];
  end

  assign lfsr_o = chain[OUT_W];

endmodule

// File: rtl/pn_lfsr_stream_gen.sv
// Seeded PN stream source: loads seed/length, emits OUT_W LFSR bits per beat on a backpressured stream with TLAST.
module pn_lfsr_stream_gen import pn_gen_pkg::*; #(
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] TAPS   = 7'b1100000,
  parameter int                OUT_W  = 8,
  parameter int                LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic [LFSR_W-1:0] seed_data,
  input  logic [LEN_W-1:0]  seed_len,
  input  logic              abort,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [OUT_W-1:0]  m_tdata,
  output logic              m_tlast,
  output logic              busy,
  output logic              seed_zero_err
);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              seed_ready_q, seed_ready_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic [OUT_W-1:0]  m_tdata_q, m_tdata_d;
  logic              m_tlast_q, m_tlast_d;
  logic              busy_q, busy_d;
  logic              seed_zero_err_q, seed_zero_err_d;

  logic [LFSR_W-1:0] seed_eff, unroll_in, unroll_next;
  logic [OUT_W-1:0]  unroll_bits;
  logic              load;

  // The all-zero state would lock up the LFSR, so it is replaced by 1.
  assign seed_eff  = (seed_data == '0) ? LFSR_W'(1) : seed_data;
  assign load      = seed_valid && seed_ready_q;
  assign unroll_in = (state_q == IDLE) ? seed_eff : lfsr_q;

  pn_lfsr_unroll #(.LFSR_W(LFSR_W), .TAPS(TAPS), .OUT_W(OUT_W)) u_unroll (
    .lfsr_i (unroll_in),
    .bits_o (unroll_bits),
    .lfsr_o (unroll_next)
  );

  always_comb begin
    state_d         = state_q;
    lfsr_d          = lfsr_q;
    count_d         = count_q;
    m_tvalid_d      = m_tvalid_q;
    m_tdata_d       = m_tdata_q;
    m_tlast_d       = m_tlast_q;
    seed_zero_err_d = 1'b0;
    if (state_q == IDLE) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
      if (load) begin
        seed_zero_err_d = (seed_data == '0);
        if (seed_len == '0) begin
          lfsr_d = seed_eff;
        end else begin
          lfsr_d     = unroll_next;
          m_tdata_d  = unroll_bits;
          m_tvalid_d = 1'b1;
          m_tlast_d  = (seed_len == LEN_W'(1));
          count_d    = seed_len - LEN_W'(1);
          state_d    = RUN;
        end
      end
    end else begin
      // Abort wins over a same-cycle handshake: the offered beat is dropped.
      if (abort) begin
        m_tvalid_d = 1'b0;
        m_tlast_d  = 1'b0;
        state_d    = IDLE;
      end else if (m_tvalid_q && m_tready) begin
        if (m_tlast_q) begin
          m_tvalid_d = 1'b0;
          m_tlast_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          lfsr_d    = unroll_next;
          m_tdata_d = unroll_bits;
          m_tlast_d = (count_q == LEN_W'(1));
          count_d   = count_q - LEN_W'(1);
        end
      end
    end
    seed_ready_d = (state_d == IDLE);
    busy_d       = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      lfsr_q          <= LFSR_W'(1);
      count_q         <= '0;
      seed_ready_q    <= 1'b0;
      m_tvalid_q      <= 1'b0;
      m_tdata_q       <= '0;
      m_tlast_q       <= 1'b0;
      busy_q          <= 1'b0;
      seed_zero_err_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      count_q         <= count_d;
      seed_ready_q    <= seed_ready_d;
      m_tvalid_q      <= m_tvalid_d;
      m_tdata_q       <= m_tdata_d;
      m_tlast_q       <= m_tlast_d;
      busy_q          <= busy_d;
      seed_zero_err_q <= seed_zero_err_d;
    end
  end

  assign seed_ready    = seed_ready_q;
  assign m_tvalid      = m_tvalid_q;
  assign m_tdata       = m_tdata_q;
  assign m_tlast       = m_tlast_q;
  assign busy          = busy_q;
  assign seed_zero_err = seed_zero_err_q;

endmodule

// File: tb/tb_pn_lfsr_stream_gen.sv
// Bench for pn_lfsr_stream_gen (3-bit LFSR, taps 011, 7 bits/beat): directed cases plus random traffic vs a beat-queue model.
module tb_pn_lfsr_stream_gen;

  localparam int LFSR_W = 3;
  localparam int OUT_W  = 7;
  localparam int LEN_W  = 4;
  localparam int TAPS_I = 3;

  logic              clk;
  logic              reset;
  logic              seed_valid;
  logic              seed_ready;
  logic [LFSR_W-1:0] seed_data;
  logic [LEN_W-1:0]  seed_len;
  logic              abort;
  logic              m_tvalid;
  logic              m_tready;
  logic [OUT_W-1:0]  m_tdata;
  logic              m_tlast;
  logic              busy;
  logic              seed_zero_err;

  pn_lfsr_stream_gen #(.LFSR_W(LFSR_W), .TAPS(3'b011), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed_data(seed_data), .seed_len(seed_len), .abort(abort), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast), .busy(busy),
    .seed_zero_err(seed_zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: beats still owed by the current run, plus hold/pulse expectations.
  int          exp_q[$];
  logic        zerr_exp  = 1'b0;
  logic        fresh     = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole run of beats straight from the shift/xor definition of the sequence.
  function automatic void gen_run(input int seed, input int len);
    int s;
    int beat;
    int fb;
    s = (seed == 0) ? 1 : seed;
    for (int b = 0; b < len; b++) begin
      beat = 0;
      for (int k = 0; k < OUT_W; k++) begin
        beat = beat | ((s & 1) << k);
        fb   = $countones(s & TAPS_I) & 1;
        s    = (s >> 1) | (fb << (LFSR_W - 1));
      end
      exp_q.push_back(beat);
    end
  endfunction

  task automatic sample();
    logic zerr_next;
    logic active;
    active    = (exp_q.size() > 0);
    zerr_next = 1'b0;
    chk("tvalid", m_tvalid, active);
    chk("busy", busy, active);
    chk("seed_ready", seed_ready, fresh ? 1'b0 : !active);
    chk("zero_err", seed_zero_err, zerr_exp);
    fresh = 1'b0;
    if (prev_hold) begin
      chk("hold_valid", m_tvalid, 1'b1);
      chk("hold_data", m_tdata, prev_data);
      chk("hold_last", m_tlast, prev_last);
    end
    prev_hold = m_tvalid && !m_tready && !abort;
    prev_data = 32'(m_tdata);
    prev_last = m_tlast;
    if (active) begin
      if (abort) exp_q.delete();
      else if (m_tvalid && m_tready) begin
        chk("beat_data", m_tdata, exp_q[0]);
        chk("beat_last", m_tlast, exp_q.size() == 1);
        void'(exp_q.pop_front());
      end
    end else if (seed_valid && seed_ready) begin
      zerr_next = (seed_data == '0);
      gen_run(int'(seed_data), int'(seed_len));
    end
    zerr_exp = zerr_next;
  endtask

  task automatic tick();
    @(negedge clk);
    if (reset) sample();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int s, input int len);
    seed_valid = 1'b1;
    seed_data  = LFSR_W'(s);
    seed_len   = LEN_W'(len);
    tick();
    seed_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    abort = 1'b0; m_tready = 1'b1; seed_valid = 1'b0;
    budget = 40;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_done", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; seed_valid = 1'b0; seed_data = '0; seed_len = '0;
    abort = 1'b0; m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", seed_ready, 0);
    chk("rst_valid", m_tvalid, 0);
    chk("rst_data", m_tdata, 0);
    chk("rst_last", m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zerr", seed_zero_err, 0);
    #1 reset = 1'b1;
    fresh = 1'b1;
    tick();
    chk("ready_after_rst", seed_ready, 1);

    // 1: two beats back to back
    m_tready = 1'b1;
    load(1, 2);
    chk("t1_beat0", m_tdata, 32'h69);
    chk("t1_last0", m_tlast, 0);
    tick();
    chk("t1_beat1", m_tdata, 32'h69);
    chk("t1_last1", m_tlast, 1);
    tick();
    chk("t1_ready", seed_ready, 1);
    chk("t1_idle", m_tvalid, 0);

    // 2: backpressure holds the first beat
    m_tready = 1'b0;
    load(1, 2);
    repeat (5) begin
      chk("t2_held", m_tdata, 32'h69);
      tick();
    end
    m_tready = 1'b1;
    tick();
    chk("t2_one_beat", m_tlast, 1);
    drain();

    // 3: zero seed replaced
    load(0, 1);
    chk("t3_zerr", seed_zero_err, 1);
    chk("t3_beat", m_tdata, 32'h69);
    chk("t3_last", m_tlast, 1);
    tick();
    chk("t3_zerr_gone", seed_zero_err, 0);
    drain();

    // 4: zero length, then immediate reload
    load(5, 0);
    chk("t4_novalid", m_tvalid, 0);
    chk("t4_ready", seed_ready, 1);
    load(1, 1);
    chk("t4_reload", m_tvalid, 1);
    drain();

    // 5: abort after three handshakes
    load(1, 15);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_valid", m_tvalid, 0);
    chk("t5_last", m_tlast, 0);
    chk("t5_busy", busy, 0);
    tick();
    load(1, 2);
    chk("t5_new", m_tdata, 32'h69);
    drain();

    // 6: asynchronous reset mid-run
    m_tready = 1'b0;
    load(1, 15);
    chk("t6_running", m_tvalid, 1);
    #1 reset = 1'b0;
    #1;
    chk("t6_valid", m_tvalid, 0);
    chk("t6_last", m_tlast, 0);
    chk("t6_data", m_tdata, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", seed_ready, 0);
    exp_q.delete();
    prev_hold = 1'b0;
    zerr_exp  = 1'b0;
    #1 reset = 1'b1;
    fresh = 1'b1;
    tick();
    chk("t6_ready_clk", seed_ready, 1);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      seed_valid = ($urandom_range(0, 99) < 40);
      seed_data  = LFSR_W'($urandom_range(0, 7));
      seed_len   = LEN_W'($urandom_range(0, 15));
      m_tready   = ($urandom_range(0, 99) < 70);
      abort      = ($urandom_range(0, 99) < 3);
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
